icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Miss handler and sequencer for the direct-mapped instruction cache.
- On a fetch miss, reads the missing line plus 2 trailing bytes from the memory arbiter's byte-wide read port, assembles the fill block and writes it into the cache in one cycle. The trailing bytes cover a misaligned compressed-extension instruction at the end of a line.
- Sits between the instruction-fetch unit, the instruction cache and the memory arbiter.
- Drives the cache address and write-enable while a fill is in progress.

Parameters:
- ADDR_W, 32, fetch/memory address width.
- BLOCK_BYTES, 16, line size in bytes; power of two, at least 4.
- OFFSET_BIT, 4, log2(BLOCK_BYTES).
- FILL_BYTES, BLOCK_BYTES+2, bytes fetched per refill; derived, not overridable.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global ready; when low, all state is frozen.
- fetch_valid  in  1  IF is requesting an instruction at fetch_addr.
- fetch_addr  in  ADDR_W  fetch PC.
- cache_hit  in  1  hit from the cache for cache_addr.
- fetch_ready  out  1  cache_hit && state==IDLE; IF may consume the cache data.
- cache_addr  out  ADDR_W  fetch_addr in IDLE; latched fill_base while a fill is in progress.
- cache_we  out  1  one-cycle fill write strobe.
- cache_block  out  FILL_BYTES*8  assembled fill data; byte i at bits [8i+7:8i].
- mem_req_valid  out  1  byte read request.
- mem_req_addr  out  ADDR_W  byte address of the request.
- mem_req_ready  in  1  arbiter accepts the request this cycle.
- mem_rsp_valid  in  1  read data valid; responses return in request order.
- mem_rsp_data  in  8  read byte.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE, counters=0, buffer=0, cache_we=0, mem_req_valid=0, busy=0.
- All updates occur only on a rising clk_in with rdy_in=1 and rst_in=0.
- IDLE:
  - If fetch_valid && !cache_hit: latch fill_base = fetch_addr with the low OFFSET_BIT bits cleared; clear issue_cnt and recv_cnt; go to REQ.
  - The miss is detected in the same cycle, so miss-to-REQ latency is 1 cycle.
- REQ:
  - mem_req_valid=1 and mem_req_addr = fill_base + issue_cnt, modulo 2^ADDR_W (wrap at the top of the address space is legal).
  - On mem_req_ready, issue_cnt increments. After the handshake with issue_cnt == FILL_BYTES-1, go to WAIT.
  - mem_req_valid and mem_req_addr hold stable until accepted.
  - Back-to-back issue is allowed, one request per accepted cycle.
- Receive, in REQ or WAIT:
  - On mem_rsp_valid, buffer byte[recv_cnt] <= mem_rsp_data and recv_cnt increments.
  - A response may arrive in the same cycle as a request handshake; both counters update independently.
- WAIT:
  - mem_req_valid=0.
  - When a response arrives with recv_cnt == FILL_BYTES-1, go to WRITE.
  - If the last response arrives while still in REQ, the FSM goes directly to WRITE.
- WRITE:
  - cache_we=1 for exactly one cycle, with cache_block = buffer and cache_addr = fill_base. Then go to IDLE.
  - The next IDLE cycle re-evaluates cache_hit, so the refilled address hits there.
  - Miss-to-fetch_ready latency with a zero-wait arbiter and 1-cycle response latency is FILL_BYTES+3 cycles.
- Responses with mem_rsp_valid in IDLE or WRITE are ignored. Bench checkers flag them as a protocol error.
- fetch_addr changes during a fill (branch redirect): the fill completes and writes the original line. The new address is evaluated in IDLE afterwards, so no abort path exists.
- Reset mid-fill: return to IDLE immediately; the partial buffer is discarded and no cache write occurs. The arbiter is reset on the same rst_in.
- rdy_in low: counters, state and buffer hold; outputs hold their current values, and cache_we is held low.
- Counter widths: clog2(FILL_BYTES)+1 bits. The counters never exceed FILL_BYTES.

Optional Feature:
- Macro: ICACHE_REFILL_STATS_EN.
- Defined: adds outputs stat_access[31:0] and stat_miss[31:0].
  - stat_access increments on each IDLE cycle with fetch_valid && cache_hit.
  - stat_miss increments on each IDLE-to-REQ transition.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared header const.v: ICACHE_BLOCK_BIT, ICACHE_OFFSET_BIT, ICACHE_INDEX_BIT, ICACHE_TAG_BIT; state encodings REFILL_IDLE, REFILL_REQ, REFILL_WAIT, REFILL_WRITE as 2-bit localparams.
- One sub-module: icache_fill_buffer. It holds the FILL_BYTES-byte shift/indexed buffer and recv_cnt, and asserts a done flag on the last byte. The FSM and issue counter stay in the top module.

Test Plan:
- Miss at 0x00001236, arbiter always ready, 1-cycle response: requests cover 0x1230..0x1241 (18 bytes). cache_we pulses once with fill_base 0x1230, and byte 17 of the block equals memory[0x1241]. fetch_ready rises 21 cycles after the miss.
- Hit on a line already filled: fetch_ready=1 the same cycle, no mem_req_valid, busy stays 0.
- Random mem_req_ready stalls (50%) and 0-3 cycle response delay: the assembled block is byte-exact against the memory model. mem_req_addr stays stable while unaccepted.
- Fill at fill_base 0xFFFFFFF0: request addresses wrap to 0x00000000 and 0x00000001 for bytes 16 and 17.
- rst_in asserted after 7 responses: state returns to IDLE next cycle, no cache_we, and the next miss refetches all 18 bytes. rdy_in held low for 5 cycles mid-fill produces no counter change.
- With ICACHE_REFILL_STATS_EN: 3 misses and 10 hits give stat_miss=3 and stat_access=10.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl_pkg
// Shared constants for the direct-mapped instruction cache and its refill
// sequencer: geometry of the cache line/address split, the refill FSM state
// encoding and a helper for sizing the refill byte counters.
// -----------------------------------------------------------------------------
package icache_refill_ctrl_pkg;

   // Cache geometry: 16-byte lines, 256 sets, 32-bit addresses.
   localparam int ICACHE_BLOCK_BIT  = 128;
   localparam int ICACHE_OFFSET_BIT = 4;
   localparam int ICACHE_INDEX_BIT  = 8;
   localparam int ICACHE_TAG_BIT    = 32 - ICACHE_INDEX_BIT - ICACHE_OFFSET_BIT;

   // Refill sequencer states (2-bit encoding).
   typedef enum logic [1:0] {
      REFILL_IDLE  = 2'd0,
      REFILL_REQ   = 2'd1,
      REFILL_WAIT  = 2'd2,
      REFILL_WRITE = 2'd3
   } refill_state_e;

   // Counters must hold the value FILL_BYTES itself, hence the extra bit.
   function automatic int cnt_width(input int fill_bytes);
      return $clog2(fill_bytes) + 1;
   endfunction

endpackage

// File: rtl/icache_fill_buffer.sv
// -----------------------------------------------------------------------------
// icache_fill_buffer
// Collects the response bytes of one refill into an indexed buffer and counts
// them. o_done is raised in the cycle the last byte is being captured, so the
// sequencer can move to its write state on the same edge.
//
// Ports:
//   clk_in     in   clock
//   rst_in     in   synchronous active-high reset
//   rdy_in     in   global ready; state frozen when low
//   i_clear    in   start of a new refill; restarts the byte counter
//   i_capture  in   a response byte is valid and belongs to the current fill
//   i_data     in   response byte
//   o_block    out  assembled fill data, byte i at bits [8i+7:8i]
//   o_done     out  capture of byte FILL_BYTES-1 is happening this cycle
// -----------------------------------------------------------------------------
module icache_fill_buffer #(
   parameter int FILL_BYTES = 18,
   parameter int CNT_W      = 6
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    i_clear,
   input  logic                    i_capture,
   input  logic [7:0]              i_data,
   output logic [FILL_BYTES*8-1:0] o_block,
   output logic                    o_done
);

   logic [FILL_BYTES-1:0][7:0] r_buf;
   logic [CNT_W-1:0]           r_recv_cnt;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         // NOTE: the buffer is a bank of flops, not a RAM, so it can and does
         // take a reset; a fill cut short by reset leaves no stale bytes.
         r_buf      <= '0;
         r_recv_cnt <= '0;
      end else if (rdy_in) begin
         if (i_clear) begin
            r_recv_cnt <= '0;
         end else if (i_capture) begin
            for (int i = 0; i < FILL_BYTES; i++) begin
               if (r_recv_cnt == CNT_W'(i)) r_buf[i] <= i_data;
            end
            r_recv_cnt <= r_recv_cnt + CNT_W'(1);
         end
      end
   end

   assign o_block = r_buf;
   assign o_done  = i_capture && (r_recv_cnt == CNT_W'(FILL_BYTES - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Miss handler for the direct-mapped instruction cache. On a fetch miss it
// reads the line plus two trailing bytes (for a compressed instruction that
// straddles the line end) over the arbiter's byte-wide port, then writes the
// assembled block into the cache in a single cycle.
//
// Optional build macro ICACHE_REFILL_STATS_EN adds saturating access/miss
// counters on stat_access / stat_miss.
//
// Ports:
//   clk_in, rst_in, rdy_in     clock, sync active-high reset, global ready
//   fetch_valid, fetch_addr    fetch request from IF
//   cache_hit                  hit for cache_addr
//   fetch_ready                hit while idle; IF may take the cache data
//   cache_addr                 fetch_addr when idle, fill base otherwise
//   cache_we, cache_block      one-cycle fill write strobe and data
//   mem_req_valid/addr/ready   byte read request to the arbiter
//   mem_rsp_valid/data         in-order read responses
//   busy                       a refill is in progress
//   stat_access, stat_miss     (ICACHE_REFILL_STATS_EN only) statistics
// -----------------------------------------------------------------------------
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BLOCK_BYTES = ICACHE_BLOCK_BIT / 8,
   parameter int OFFSET_BIT  = ICACHE_OFFSET_BIT
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         rdy_in,
   input  logic                         fetch_valid,
   input  logic [ADDR_W-1:0]            fetch_addr,
   input  logic                         cache_hit,
   output logic                         fetch_ready,
   output logic [ADDR_W-1:0]            cache_addr,
   output logic                         cache_we,
   output logic [(BLOCK_BYTES+2)*8-1:0] cache_block,
   output logic                         mem_req_valid,
   output logic [ADDR_W-1:0]            mem_req_addr,
   input  logic                         mem_req_ready,
   input  logic                         mem_rsp_valid,
   input  logic [7:0]                   mem_rsp_data,
   output logic                         busy
`ifdef ICACHE_REFILL_STATS_EN
   ,
   output logic [31:0]                  stat_access,
   output logic [31:0]                  stat_miss
`endif
);

   localparam int FILL_BYTES = BLOCK_BYTES + 2;
   localparam int CNT_W      = cnt_width(FILL_BYTES);

   refill_state_e     r_state;
   logic [ADDR_W-1:0] r_fill_base;
   logic [CNT_W-1:0]  r_issue_cnt;

   logic w_idle;
   logic w_miss;
   logic w_req_hs;
   logic w_last_issue;
   logic w_capture;
   logic w_done;

   assign w_idle       = (r_state == REFILL_IDLE);
   assign w_miss       = w_idle && fetch_valid && !cache_hit;
   assign w_req_hs     = (r_state == REFILL_REQ) && mem_req_ready;
   assign w_last_issue = (r_issue_cnt == CNT_W'(FILL_BYTES - 1));
   // Responses only belong to a fill while requests are outstanding.
   assign w_capture    = mem_rsp_valid &&
                         ((r_state == REFILL_REQ) || (r_state == REFILL_WAIT));

   icache_fill_buffer #(
      .FILL_BYTES (FILL_BYTES),
      .CNT_W      (CNT_W)
   ) u_fill_buffer (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .i_clear   (w_miss),
      .i_capture (w_capture),
      .i_data    (mem_rsp_data),
      .o_block   (cache_block),
      .o_done    (w_done)
   );

   always_ff @(posedge clk_in) begin
      // NOTE: every register here uses <= so all of them see the pre-edge
      // values of each other, whatever order the statements are written in.
      if (rst_in) begin
         r_state     <= REFILL_IDLE;
         r_fill_base <= '0;
         r_issue_cnt <= '0;
      end else if (rdy_in) begin
         case (r_state)
            REFILL_IDLE: begin
               if (w_miss) begin
                  r_fill_base <= {fetch_addr[ADDR_W-1:OFFSET_BIT], {OFFSET_BIT{1'b0}}};
                  r_issue_cnt <= '0;
                  r_state     <= REFILL_REQ;
               end
            end
            REFILL_REQ: begin
               if (w_req_hs) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
               // A last response can only beat the last handshake with a
               // combinational arbiter; it still goes straight to WRITE.
               if (w_done)                        r_state <= REFILL_WRITE;
               else if (w_req_hs && w_last_issue) r_state <= REFILL_WAIT;
            end
            REFILL_WAIT: begin
               if (w_done) r_state <= REFILL_WRITE;
            end
            REFILL_WRITE: r_state <= REFILL_IDLE;
            default:      r_state <= REFILL_IDLE;
         endcase
      end
   end

   assign fetch_ready   = cache_hit && w_idle;
   assign cache_addr    = w_idle ? fetch_addr : r_fill_base;
   // Held low while frozen so a stalled WRITE state cannot repeat the write.
   assign cache_we      = (r_state == REFILL_WRITE) && rdy_in;
   assign mem_req_valid = (r_state == REFILL_REQ);
   // Wraps naturally at the top of the address space.
   assign mem_req_addr  = r_fill_base + ADDR_W'(r_issue_cnt);
   assign busy          = !w_idle;

`ifdef ICACHE_REFILL_STATS_EN
   logic [31:0] r_stat_access;
   logic [31:0] r_stat_miss;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_stat_access <= '0;
         r_stat_miss   <= '0;
      end else if (rdy_in) begin
         if (w_idle && fetch_valid && cache_hit && (r_stat_access != '1))
            r_stat_access <= r_stat_access + 32'd1;
         if (w_miss && (r_stat_miss != '1))
            r_stat_miss <= r_stat_miss + 32'd1;
      end
   end

   assign stat_access = r_stat_access;
   assign stat_miss   = r_stat_miss;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
// Directed bench for icache_refill_ctrl: a byte-addressed memory model behind
// an arbiter model (optional random stalls and response delay) and a small
// tag-store cache model that supplies cache_hit. Inputs change 1 ns after the
// rising edge; the arbiter model acts on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_icache_refill_ctrl;

   localparam int FILL = 18;

   logic              clk_in;
   logic              rst_in;
   logic              rdy_in;
   logic              fetch_valid;
   logic [31:0]       fetch_addr;
   logic              cache_hit;
   logic              fetch_ready;
   logic [31:0]       cache_addr;
   logic              cache_we;
   logic [FILL*8-1:0] cache_block;
   logic              mem_req_valid;
   logic [31:0]       mem_req_addr;
   logic              mem_req_ready;
   logic              mem_rsp_valid;
   logic [7:0]        mem_rsp_data;
   logic              busy;
`ifdef ICACHE_REFILL_STATS_EN
   logic [31:0]       stat_access;
   logic [31:0]       stat_miss;
`endif

   icache_refill_ctrl dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .fetch_valid   (fetch_valid),
      .fetch_addr    (fetch_addr),
      .cache_hit     (cache_hit),
      .fetch_ready   (fetch_ready),
      .cache_addr    (cache_addr),
      .cache_we      (cache_we),
      .cache_block   (cache_block),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .busy          (busy)
`ifdef ICACHE_REFILL_STATS_EN
      ,
      .stat_access   (stat_access),
      .stat_miss     (stat_miss)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Memory contents: a fixed hash of the byte address.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [FILL*8-1:0] exp_block(input logic [31:0] base);
      logic [FILL*8-1:0] b;
      for (int i = 0; i < FILL; i++) b[8*i +: 8] = mem_byte(base + 32'(i));
      return b;
   endfunction

   // ---------------- cache model: 16 sets, tag = addr[31:8] ----------------
   bit                tag_v [16];
   logic [23:0]       tag_a [16];
   int                we_cnt = 0;
   logic [31:0]       last_we_addr = '0;
   logic [FILL*8-1:0] last_block = '0;

   assign cache_hit = tag_v[cache_addr[7:4]] && (tag_a[cache_addr[7:4]] == cache_addr[31:8]);

   always @(posedge clk_in) begin
      if (!rst_in && cache_we) begin
         tag_v[cache_addr[7:4]] <= 1'b1;
         tag_a[cache_addr[7:4]] <= cache_addr[31:8];
         we_cnt       <= we_cnt + 1;
         last_we_addr <= cache_addr;
         last_block   <= cache_block;
      end
   end

   // ---------------- arbiter model ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   rsp_t        rsp_q [$];
   logic [31:0] req_log [$];
   int          edge_cnt = 0;
   int          rsp_cnt = 0;
   int          unstable_cnt = 0;
   bit          rand_mode = 1'b0;
   bit          pend_valid = 1'b0;
   logic [31:0] pend_addr = '0;

   always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

   always @(negedge clk_in) begin
      int ne;
      rsp_t r;
      ne = edge_cnt + 1;
      if (rst_in) begin
         rsp_q.delete();
         pend_valid    = 1'b0;
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
      end else if (!rdy_in) begin
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
      end else begin
         mem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pend_valid && mem_req_valid && (mem_req_addr !== pend_addr)) unstable_cnt++;
         if (mem_req_valid && mem_req_ready) begin
            req_log.push_back(mem_req_addr);
            r.addr = mem_req_addr;
            r.due  = ne + 1 + (rand_mode ? int'($urandom_range(0, 3)) : 0);
            rsp_q.push_back(r);
            pend_valid = 1'b0;
         end else begin
            pend_valid = mem_req_valid;
            pend_addr  = mem_req_addr;
         end
         if (rsp_q.size() > 0 && rsp_q[0].due <= ne) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_byte(rsp_q[0].addr);
            void'(rsp_q.pop_front());
            rsp_cnt++;
         end else begin
            mem_rsp_valid = 1'b0;
         end
      end
   end

   // Starts a fill at addr, waits (bounded) for the cache write, checks it.
   task automatic run_fill(input logic [31:0] addr, input bit hold_valid, output int cycles);
      logic [31:0] base;
      int w0;
      base = {addr[31:4], 4'h0};
      req_log.delete();
      w0          = we_cnt;
      fetch_addr  = addr;
      fetch_valid = 1'b1;
      tick();
      cycles = 1;
      check("miss_to_req", {busy, mem_req_valid}, 2'b11);
      if (!hold_valid) fetch_valid = 1'b0;
      while (we_cnt == w0 && cycles < 2000) begin
         tick();
         cycles++;
      end
      check("fill_we_count", we_cnt - w0, 1);
      check("fill_we_addr", last_we_addr, base);
      check("fill_block", last_block, exp_block(base));
      check("fill_req_count", req_log.size(), FILL);
      check("fill_back_idle", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int cyc;
   int bad;
   int w0;
   int r0;
   int n;
   int n_req;

   initial begin
      rst_in      = 1'b1;
      rdy_in      = 1'b1;
      fetch_valid = 1'b0;
      fetch_addr  = 32'h0000_0ABC;
      repeat (2) tick();
      check("rst_busy", busy, 1'b0);
      check("rst_req_valid", mem_req_valid, 1'b0);
      check("rst_we", cache_we, 1'b0);
      check("rst_block", cache_block, '0);
      rst_in = 1'b0;
      tick();
      check("idle_cache_addr", cache_addr, 32'h0000_0ABC);
      check("idle_not_ready", fetch_ready, 1'b0);

      // Miss at 0x1236, zero-wait arbiter, 1-cycle responses.
      run_fill(32'h0000_1236, 1'b1, cyc);
      check("miss_latency", cyc, 21);
      check("ready_after_fill", fetch_ready, 1'b1);
      check("byte17", last_block[143:136], mem_byte(32'h0000_1241));
      bad = 0;
      for (int i = 0; i < req_log.size(); i++)
         if (req_log[i] !== 32'h0000_1230 + 32'(i)) bad++;
      check("req_sequence", bad, 0);
      if (req_log.size() == FILL) check("req_last", req_log[17], 32'h0000_1241);

      // Hit on the filled line.
      req_log.delete();
      fetch_addr = 32'h0000_123C;
      #1;
      check("hit_ready", fetch_ready, 1'b1);
      check("hit_no_req", {busy, mem_req_valid}, 2'b00);
      repeat (4) tick();
      check("hit_still_idle", busy, 1'b0);
      check("hit_req_log", req_log.size(), 0);

      // Random stalls and response delays.
      rand_mode    = 1'b1;
      unstable_cnt = 0;
      run_fill(32'h0000_2A5B, 1'b1, cyc);
      rand_mode = 1'b0;
      check("addr_stable", unstable_cnt, 0);
      check("rand_ready", fetch_ready, 1'b1);

      // Address-space wrap.
      run_fill(32'hFFFF_FFF7, 1'b1, cyc);
      if (req_log.size() == FILL) begin
         check("wrap_req0", req_log[0], 32'hFFFF_FFF0);
         check("wrap_req16", req_log[16], 32'h0000_0000);
         check("wrap_req17", req_log[17], 32'h0000_0001);
      end

      // Reset after 7 responses.
      req_log.delete();
      w0          = we_cnt;
      r0          = rsp_cnt;
      fetch_addr  = 32'h0000_3408;
      fetch_valid = 1'b1;
      tick();
      n = 0;
      while (rsp_cnt - r0 < 7 && n < 200) begin
         tick();
         n++;
      end
      check("rst_after7", rsp_cnt - r0, 7);
      fetch_valid = 1'b0;
      rst_in      = 1'b1;
      tick();
      rst_in = 1'b0;
      check("rst_mid_idle", busy, 1'b0);
      check("rst_mid_req", mem_req_valid, 1'b0);
      check("rst_mid_buf", cache_block, '0);
      tick();
      check("rst_mid_no_we", we_cnt - w0, 0);
      run_fill(32'h0000_3408, 1'b1, cyc);
      if (req_log.size() == FILL) check("refetch_req0", req_log[0], 32'h0000_3400);

      // rdy_in low for 5 cycles mid-fill.
      req_log.delete();
      w0          = we_cnt;
      fetch_addr  = 32'h0000_4440;
      fetch_valid = 1'b1;
      tick();
      repeat (5) tick();
      n_req = req_log.size();
      check("frz_pre_reqs", n_req, 5);
      r0     = rsp_cnt;
      rdy_in = 1'b0;
      repeat (5) tick();
      check("frz_req_log", req_log.size(), 5);
      check("frz_rsp", rsp_cnt - r0, 0);
      check("frz_addr", mem_req_addr, 32'h0000_4445);
      check("frz_busy", {busy, mem_req_valid}, 2'b11);
      check("frz_we", cache_we, 1'b0);
      rdy_in = 1'b1;
      n = 0;
      while (we_cnt == w0 && n < 2000) begin
         tick();
         n++;
      end
      check("frz_we_count", we_cnt - w0, 1);
      check("frz_block", last_block, exp_block(32'h0000_4440));
      check("frz_req_count", req_log.size(), FILL);

`ifdef ICACHE_REFILL_STATS_EN
      fetch_valid = 1'b0;
      rst_in      = 1'b1;
      tick();
      rst_in = 1'b0;
      tick();
      run_fill(32'h0000_5500, 1'b0, cyc);
      run_fill(32'h0000_5610, 1'b0, cyc);
      run_fill(32'h0000_5720, 1'b0, cyc);
      fetch_addr  = 32'h0000_5614;
      fetch_valid = 1'b1;
      repeat (10) tick();
      fetch_valid = 1'b0;
      tick();
      check("stat_miss", stat_miss, 32'd3);
      check("stat_access", stat_access, 32'd10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
